// File: rtl/clk_mux_pkg.sv
// Shared types for the clock-mux failover logic: FSM state encoding and select values.
package clk_mux_pkg;

    typedef enum logic [2:0] {
        ST_PRI      = 3'd0,
        ST_HOLD_BAK = 3'd1,
        ST_BAK      = 3'd2,
        ST_HOLD_PRI = 3'd3,
        ST_FAULT    = 3'd4
    } clk_mux_state_e;

    localparam logic SEL_PRI = 1'b0;
    localparam logic SEL_BAK = 1'b1;

endpackage

// File: rtl/clk_mux_holdoff_timer.sv
// Holdoff down-counter: load HOLDOFF_CYCLES-1, decrement to zero, flag zero.
module clk_mux_holdoff_timer #(
    parameter int HOLDOFF_CYCLES = 1024
) (
    input  logic clk_ref,
    input  logic reset_in,
    input  logic load,
    input  logic dec,
    output logic zero
);

    localparam int W = $clog2(HOLDOFF_CYCLES + 1);

    // NOTE: declaration initializers give the same power-up value as reset on FPGA targets.
    logic [W-1:0] cnt_q = '0;
    logic [W-1:0] cnt_d;

    // NOTE: assign a default first in every always_comb so no latch is inferred.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = W'(HOLDOFF_CYCLES - 1);
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    // NOTE: non-blocking assignments so every register updates from pre-edge values.
    always_ff @(posedge clk_ref) begin
        if (reset_in) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/clk_failover_ctrl.sv
// Primary/backup clock failover controller driving a BUFGMUX select, with
// holdoff after each switch, optional auto-revert, and a saturating switch counter.
module clk_failover_ctrl
    import clk_mux_pkg::*;
#(
    parameter int HOLDOFF_CYCLES = 1024,
    parameter int RECOVER_CYCLES = 12500000,
    parameter int AUTO_REVERT    = 1,
    parameter int SWCNT_WIDTH    = 16
) (
    input  logic                   clk_ref,
    input  logic                   reset_in,
    input  logic                   stopped_pri,
    input  logic                   stopped_bak,
    output logic                   clk_sel,
    output logic                   all_stopped,
    output logic                   switch_pulse,
    output logic [SWCNT_WIDTH-1:0] switch_count,
    output logic [2:0]             state
);

    localparam int REC_W = $clog2(RECOVER_CYCLES + 1);
    localparam logic [REC_W-1:0] REC_MAX = REC_W'(RECOVER_CYCLES - 1);

    clk_mux_state_e         state_q = ST_PRI;
    clk_mux_state_e         state_d;
    logic                   clk_sel_q = SEL_PRI;
    logic                   clk_sel_d;
    logic                   all_stopped_q = 1'b0;
    logic                   all_stopped_d;
    logic                   switch_pulse_q = 1'b0;
    logic                   switch_pulse_d;
    logic [SWCNT_WIDTH-1:0] switch_count_q = '0;
    logic [SWCNT_WIDTH-1:0] switch_count_d;
    logic [REC_W-1:0]       rec_q = '0;
    logic [REC_W-1:0]       rec_d;

    logic timer_load;
    logic timer_dec;
    logic timer_zero;

    clk_mux_holdoff_timer #(
        .HOLDOFF_CYCLES(HOLDOFF_CYCLES)
    ) u_holdoff (
        .clk_ref (clk_ref),
        .reset_in(reset_in),
        .load    (timer_load),
        .dec     (timer_dec),
        .zero    (timer_zero)
    );

    always_comb begin
        state_d   = state_q;
        timer_dec = 1'b0;

        unique case (state_q)
            ST_PRI: begin
                if (stopped_pri && stopped_bak) state_d = ST_FAULT;
                else if (stopped_pri)           state_d = ST_HOLD_BAK;
            end
            ST_HOLD_BAK: begin
                timer_dec = 1'b1;
                if (timer_zero) state_d = ST_BAK;
            end
            ST_BAK: begin
                if (stopped_pri && stopped_bak) state_d = ST_FAULT;
                else if (stopped_bak)           state_d = ST_HOLD_PRI;
                else if ((AUTO_REVERT != 0) && !stopped_pri && (rec_q == REC_MAX))
                    state_d = ST_HOLD_PRI;
            end
            ST_HOLD_PRI: begin
                timer_dec = 1'b1;
                if (timer_zero) state_d = ST_PRI;
            end
            ST_FAULT: begin
                // Primary is preferred when both recover together.
                if (!stopped_pri)      state_d = clk_sel_q ? ST_HOLD_PRI : ST_PRI;
                else if (!stopped_bak) state_d = clk_sel_q ? ST_BAK : ST_HOLD_BAK;
            end
            default: state_d = ST_PRI;
        endcase

        timer_load = (state_d != state_q) &&
                     ((state_d == ST_HOLD_BAK) || (state_d == ST_HOLD_PRI));

        unique case (state_d)
            ST_HOLD_BAK, ST_BAK: clk_sel_d = SEL_BAK;
            ST_HOLD_PRI, ST_PRI: clk_sel_d = SEL_PRI;
            default:             clk_sel_d = clk_sel_q;
        endcase

        all_stopped_d  = (state_d == ST_FAULT);
        switch_pulse_d = (clk_sel_d != clk_sel_q);

        switch_count_d = switch_count_q;
        if (switch_pulse_d && (switch_count_q != '1)) begin
            switch_count_d = switch_count_q + SWCNT_WIDTH'(1);
        end

        // Counts consecutive healthy-primary samples while on backup only.
        rec_d = '0;
        if ((state_q == ST_BAK) && !stopped_pri) begin
            rec_d = (rec_q == REC_MAX) ? rec_q : rec_q + REC_W'(1);
        end
    end

    always_ff @(posedge clk_ref) begin
        if (reset_in) begin
            state_q        <= ST_PRI;
            clk_sel_q      <= SEL_PRI;
            all_stopped_q  <= 1'b0;
            switch_pulse_q <= 1'b0;
            switch_count_q <= '0;
            rec_q          <= '0;
        end else begin
            state_q        <= state_d;
            clk_sel_q      <= clk_sel_d;
            all_stopped_q  <= all_stopped_d;
            switch_pulse_q <= switch_pulse_d;
            switch_count_q <= switch_count_d;
            rec_q          <= rec_d;
        end
    end

    assign state        = state_q;
    assign clk_sel      = clk_sel_q;
    assign all_stopped  = all_stopped_q;
    assign switch_pulse = switch_pulse_q;
    assign switch_count = switch_count_q;

endmodule

// File: tb/tb_clk_failover_ctrl.sv
// Self-checking bench for clk_failover_ctrl: behavioural model compared every cycle
// plus directed scenarios with literal expectations.
module tb_clk_failover_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main instance: HOLDOFF=16, RECOVER=64, AUTO_REVERT=1, 16-bit counter.
    logic        reset_in = 1'b1, sp = 1'b0, sb = 1'b0;
    logic        sel1, all1, pulse1;
    logic [15:0] cnt1;
    logic [2:0]  st1;

    clk_failover_ctrl #(
        .HOLDOFF_CYCLES(16), .RECOVER_CYCLES(64), .AUTO_REVERT(1), .SWCNT_WIDTH(16)
    ) dut (
        .clk_ref(clk), .reset_in(reset_in), .stopped_pri(sp), .stopped_bak(sb),
        .clk_sel(sel1), .all_stopped(all1), .switch_pulse(pulse1),
        .switch_count(cnt1), .state(st1)
    );

    // Fast-switching instance with a narrow counter to reach saturation quickly.
    logic       rst2 = 1'b1, sp2 = 1'b0, sb2 = 1'b0;
    logic       sel2, all2, pulse2;
    logic [7:0] cnt2;
    logic [2:0] st2;

    clk_failover_ctrl #(
        .HOLDOFF_CYCLES(1), .RECOVER_CYCLES(4), .AUTO_REVERT(0), .SWCNT_WIDTH(8)
    ) dut_sat (
        .clk_ref(clk), .reset_in(rst2), .stopped_pri(sp2), .stopped_bak(sb2),
        .clk_sel(sel2), .all_stopped(all2), .switch_pulse(pulse2),
        .switch_count(cnt2), .state(st2)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input int actual, input int expected);
        total++;
        if (actual != expected) begin
            bad++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Model: which clock is selected, whether all clocks are down, how many
    // holdoff cycles remain, and how long the primary has been healthy.
    typedef struct {
        int sel;
        int fault;
        int hold_left;
        int healthy;
        int count;
        int pulse;
    } model_t;

    function automatic model_t model_step(model_t m, bit rst, bit p, bit b,
                                          int h, int r, bit auto_rev, int cmax);
        model_t n = m;
        if (rst) begin
            n = '{default: 0};
            return n;
        end
        n.healthy = 0;
        if (m.fault != 0) begin
            if (!p) begin
                n.fault = 0;
                if (m.sel == 1) begin n.sel = 0; n.hold_left = h; end
            end else if (!b) begin
                n.fault = 0;
                if (m.sel == 0) begin n.sel = 1; n.hold_left = h; end
            end
        end else if (m.hold_left > 0) begin
            n.hold_left = m.hold_left - 1;
        end else if (m.sel == 0) begin
            if (p && b)  n.fault = 1;
            else if (p) begin n.sel = 1; n.hold_left = h; end
        end else begin
            if (p && b)  n.fault = 1;
            else if (b) begin n.sel = 0; n.hold_left = h; end
            else if (auto_rev && !p && m.healthy >= r - 1) begin n.sel = 0; n.hold_left = h; end
            n.healthy = p ? 0 : m.healthy + 1;
        end
        n.pulse = (n.sel != m.sel) ? 1 : 0;
        if (n.pulse != 0 && n.count < cmax) n.count = n.count + 1;
        return n;
    endfunction

    function automatic int model_state(model_t m);
        if (m.fault != 0)   return 4;
        if (m.hold_left > 0) return (m.sel != 0) ? 1 : 3;
        return (m.sel != 0) ? 2 : 0;
    endfunction

    model_t m1 = '{default: 0};
    model_t m2 = '{default: 0};

    always @(posedge clk) begin
        m1 = model_step(m1, reset_in, sp, sb, 16, 64, 1'b1, 65535);
        m2 = model_step(m2, rst2, sp2, sb2, 1, 4, 1'b0, 255);
    end

    always @(negedge clk) begin
        check("m1.state",  int'(st1),    model_state(m1));
        check("m1.sel",    int'(sel1),   m1.sel);
        check("m1.all",    int'(all1),   m1.fault);
        check("m1.pulse",  int'(pulse1), m1.pulse);
        check("m1.count",  int'(cnt1),   m1.count);
        check("m2.state",  int'(st2),    model_state(m2));
        check("m2.sel",    int'(sel2),   m2.sel);
        check("m2.pulse",  int'(pulse2), m2.pulse);
        check("m2.count",  int'(cnt2),   m2.count);
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic expect1(input string tag, input int st, input int sel,
                           input int all, input int pulse, input int cnt);
        check({tag, ".state"}, int'(st1), st);
        check({tag, ".sel"},   int'(sel1), sel);
        check({tag, ".all"},   int'(all1), all);
        check({tag, ".pulse"}, int'(pulse1), pulse);
        check({tag, ".count"}, int'(cnt1), cnt);
    endtask

    initial begin
        tick(3);
        reset_in = 1'b0;
        rst2     = 1'b0;
        expect1("reset", 0, 0, 0, 0, 0);

        // Primary stops: immediate switch to backup, 16-cycle holdoff.
        sp = 1'b1; tick(1);
        expect1("fail_pri", 1, 1, 0, 1, 1);
        sp = 1'b0; tick(15);
        expect1("hold_end-1", 1, 1, 0, 0, 1);
        tick(1);
        expect1("bak_entry", 2, 1, 0, 0, 1);

        // Recovery with a glitch at cycle 40: revert 64 cycles after the glitch.
        tick(39);
        sp = 1'b1; tick(1);
        sp = 1'b0; tick(63);
        expect1("glitch+63", 2, 1, 0, 0, 1);
        tick(1);
        expect1("revert", 3, 0, 0, 1, 2);
        tick(15);
        check("hold_pri_last.state", int'(st1), 3);
        tick(1);
        expect1("back_pri", 0, 0, 0, 0, 2);

        // Both stop in PRI -> FAULT, then backup returns first.
        sp = 1'b1; sb = 1'b1; tick(1);
        expect1("fault", 4, 0, 1, 0, 2);
        tick(3);
        expect1("fault_hold", 4, 0, 1, 0, 2);
        sb = 1'b0; tick(1);
        expect1("fault_to_holdbak", 1, 1, 0, 1, 3);
        sp = 1'b0; tick(16);
        check("fault_path_bak.state", int'(st1), 2);
        sb = 1'b1; tick(1);
        expect1("bak_stop_bak", 3, 0, 0, 1, 4);
        sb = 1'b0; tick(16);
        check("pri_again.state", int'(st1), 0);

        // Stopped flags ignored during HOLD_BAK.
        sp = 1'b1; tick(1);
        expect1("hb2_entry", 1, 1, 0, 1, 5);
        sp = 1'b0; tick(2);
        sb = 1'b1; tick(5);
        check("hb2_ignore.state", int'(st1), 1);
        sb = 1'b0; tick(5);
        sb = 1'b1; tick(3);
        check("hb2_15.state", int'(st1), 1);
        tick(1);
        expect1("hb2_16", 2, 1, 0, 0, 5);
        tick(1);
        expect1("bak_to_holdpri", 3, 0, 0, 1, 6);
        sb = 1'b0; tick(16);
        check("pri3.state", int'(st1), 0);

        // Reset mid-HOLD_BAK aborts with no pulse.
        sp = 1'b1; tick(1);
        check("hb3.count", int'(cnt1), 7);
        sp = 1'b0; tick(7);
        reset_in = 1'b1; tick(1);
        expect1("rst_mid_hold", 0, 0, 0, 0, 0);
        reset_in = 1'b0; tick(1);
        expect1("after_rst", 0, 0, 0, 0, 0);

        // FAULT from BAK; both clear together -> primary wins.
        sp = 1'b1; tick(1);
        sp = 1'b0; tick(16);
        sp = 1'b1; sb = 1'b1; tick(1);
        expect1("fault_from_bak", 4, 1, 1, 0, 1);
        sp = 1'b0; sb = 1'b0; tick(1);
        expect1("both_clear", 3, 0, 0, 1, 2);
        tick(16);

        // Reset while in FAULT.
        sp = 1'b1; sb = 1'b1; tick(1);
        check("fault2.state", int'(st1), 4);
        reset_in = 1'b1; tick(1);
        expect1("rst_in_fault", 0, 0, 0, 0, 0);
        reset_in = 1'b0; sp = 1'b0; sb = 1'b0; tick(2);

        // FAULT on backup, backup returns -> BAK directly, then auto-revert.
        sp = 1'b1; tick(1);
        sp = 1'b0; tick(16);
        sp = 1'b1; sb = 1'b1; tick(1);
        sb = 1'b0; tick(1);
        expect1("fault_to_bak", 2, 1, 0, 0, 1);
        sp = 1'b0; tick(63);
        check("rec63.state", int'(st1), 2);
        tick(1);
        expect1("auto_revert", 3, 0, 0, 1, 2);
        tick(16);

        // Saturation: one switch every two cycles on the narrow instance.
        for (int i = 0; i < 20; i++) begin
            sp2 = (m2.sel == 0);
            sb2 = (m2.sel != 0);
            tick(1);
        end
        check("sat.count_20", int'(cnt2), 10);
        for (int i = 20; i < 600; i++) begin
            sp2 = (m2.sel == 0);
            sb2 = (m2.sel != 0);
            tick(1);
        end
        check("sat.count_final", int'(cnt2), 255);
        sp2 = 1'b0; sb2 = 1'b0;
        tick(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/clk_failover_ctrl.md
CLK_FAILOVER_CTRL -- requirements
Module: clk_failover_ctrl

Interface
REQ-001 The block SHALL have parameter HOLDOFF_CYCLES, default 1024, meaning the number of clk_ref cycles after any mux switch during which stopped inputs are ignored (>=1).
REQ-002 The block SHALL have parameter RECOVER_CYCLES, default 12500000, meaning the number of consecutive healthy-primary cycles required before reverting from backup (>=1).
REQ-003 The block SHALL have parameter AUTO_REVERT, default 1, meaning 1 = revert to primary after recovery and 0 = stay on backup.
REQ-004 The block SHALL have parameter SWCNT_WIDTH, default 16, meaning the width of the switch-event counter.
REQ-005 The block SHALL have port clk_ref, input, 1 bit: the single clock; one clock; reset is synchronous and active-high.
REQ-006 The block SHALL have port reset_in, input, 1 bit: synchronous active-high reset.
REQ-007 The block SHALL have port stopped_pri, input, 1 bit: primary clock out-of-range flag, synchronous to clk_ref.
REQ-008 The block SHALL have port stopped_bak, input, 1 bit: backup clock out-of-range flag, synchronous to clk_ref.
REQ-009 The block SHALL have port clk_sel, output, 1 bit: registered mux select to BUFGMUX S input (0 = primary, 1 = backup).
REQ-010 The block SHALL have port all_stopped, output, 1 bit: registered flag, high while in FAULT.
REQ-011 The block SHALL have port switch_pulse, output, 1 bit: registered one-cycle pulse on each clk_sel change.
REQ-012 The block SHALL have port switch_count, output, SWCNT_WIDTH bits: saturating count of clk_sel changes.
REQ-013 The block SHALL have port state, output, 3 bits: current FSM state encoding.

Function
REQ-014 The FSM SHALL have states PRI, HOLD_BAK, BAK, HOLD_PRI and FAULT; all outputs SHALL be registered, and an input sampled at edge N SHALL affect the outputs after edge N.
REQ-015 In PRI (clk_sel=0): stopped_pri=1 with stopped_bak=0 SHALL go to HOLD_BAK; both =1 SHALL go to FAULT; otherwise the FSM SHALL stay in PRI.
REQ-016 On entry to HOLD_BAK, clk_sel SHALL become 1 on that same edge, and the holdoff timer SHALL load HOLDOFF_CYCLES-1.
REQ-017 In HOLD_BAK, stopped inputs SHALL be ignored, the timer SHALL decrement each cycle, and at timer==0 the FSM SHALL go to BAK; HOLD_BAK therefore lasts exactly HOLDOFF_CYCLES cycles.
REQ-018 In BAK (clk_sel=1), the transitions SHALL have this priority: both stopped -> FAULT; else stopped_bak=1 -> HOLD_PRI; else if AUTO_REVERT=1 and the recovery counter has reached RECOVER_CYCLES-1 with stopped_pri=0 -> HOLD_PRI.
REQ-019 The recovery counter SHALL clear on BAK entry and on any cycle with stopped_pri=1, SHALL increment in BAK otherwise, and SHALL saturate at RECOVER_CYCLES-1.
REQ-020 HOLD_PRI SHALL mirror HOLD_BAK: clk_sel SHALL become 0 on entry, HOLD_PRI SHALL last HOLDOFF_CYCLES cycles, and the FSM SHALL then go to PRI.
REQ-021 In FAULT, clk_sel SHALL hold its value and all_stopped SHALL be 1.
REQ-022 FAULT exit SHALL be: stopped_pri=0 -> PRI if clk_sel=0, else HOLD_PRI; otherwise stopped_bak=0 -> BAK if clk_sel=1, else HOLD_BAK; primary SHALL win when both clear in the same cycle.
REQ-023 switch_pulse SHALL be 1 for exactly the cycle in which clk_sel differs from its previous value.
REQ-024 switch_count SHALL increment on the same edge that clk_sel changes, and SHALL hold at all-ones without wrap-around.
REQ-025 The state encoding SHALL be: PRI=0, HOLD_BAK=1, BAK=2, HOLD_PRI=3, FAULT=4.

Reset
REQ-026 While reset_in=1 at an edge, the block SHALL set state=PRI, clk_sel=0, all_stopped=0, switch_pulse=0, switch_count=0, holdoff timer=0 and recovery counter=0.
REQ-027 A reset asserted mid-HOLD or in FAULT SHALL abort immediately, with clk_sel=0 after that edge, and no switch_pulse or count SHALL be generated by reset.
REQ-028 All registers SHALL also carry the same values as power-up initial values.

Structure
REQ-029 The state enum typedef and its encoding SHALL reside in clk_mux_pkg, shared with the clk_mux directory.
REQ-030 The holdoff timer SHALL be a sub-module clk_mux_holdoff_timer (load, decrement, zero flag, width $clog2(HOLDOFF_CYCLES+1)); the recovery counter SHALL be inline.

Verification (HOLDOFF_CYCLES=16, RECOVER_CYCLES=64, AUTO_REVERT=1)
REQ-031 Bench SHALL cover: stopped_pri 0->1 at edge N -> clk_sel=1, switch_pulse=1 and state=1 after edge N; state=2 after edge N+16; switch_count=1.
REQ-032 Bench SHALL cover: in BAK, stopped_pri 0 for 64 cycles with a 1-cycle glitch at cycle 40 -> revert occurs only 64 cycles after the glitch; clk_sel=0; switch_count=2.
REQ-033 Bench SHALL cover: in PRI, both stopped set simultaneously -> state=4, all_stopped=1, clk_sel=0 held; then clear stopped_bak only -> HOLD_BAK, clk_sel=1.
REQ-034 Bench SHALL cover: in HOLD_BAK, toggle stopped_bak=1 for 5 cycles -> ignored, BAK reached at exactly 16 cycles, then HOLD_PRI if stopped_bak is still 1.
REQ-035 Bench SHALL cover: reset_in pulse at cycle 8 of HOLD_BAK -> state=0, clk_sel=0, switch_count=0 and no switch_pulse after that edge.
REQ-036 Bench SHALL cover: force 2^16 switches with SWCNT_WIDTH=16 -> switch_count saturates at 65535.
